lcd_write_arbiter: RTL and testbench

LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

---
 rtl/lcd_write_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_arbiter
// Function : round-robin arbiter serialising three byte-message sources and
//            display-clear requests onto a single LCD controller write port
// Revision : 1.0
// ============================================================================
module lcd_write_arbiter #(
    parameter int MAX_BYTES = 32
) (
    input  logic       I_CLK,
    input  logic       I_RST,
    input  logic [2:0] I_REQ,
    input  logic [7:0] I_DATA0,
    input  logic [7:0] I_DATA1,
    input  logic [7:0] I_DATA2,
    input  logic [2:0] I_LAST,
    input  logic       I_CLEAR,
    input  logic       I_INIT_DONE,
    input  logic       I_WRITE_DONE,
    output logic [2:0] O_GNT,
    output logic       O_BYTE_ACK,
    output logic [2:0] O_MSG_DONE,
    output logic       O_WRITE_START,
    output logic [7:0] O_DATA,
    output logic       O_CLEAR_ALL,
    output logic       O_BUSY
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);
    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    localparam logic [2:0] c_WAIT_INIT  = 3'd0;
    localparam logic [2:0] c_IDLE       = 3'd1;
    localparam logic [2:0] c_ISSUE      = 3'd2;
    localparam logic [2:0] c_WAIT_DONE  = 3'd3;
    localparam logic [2:0] c_ACK        = 3'd4;
    localparam logic [2:0] c_CLEAR      = 3'd5;
    localparam logic [2:0] c_CLEAR_WAIT = 3'd6;

    logic [2:0]       r_state, w_state_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [1:0]       r_gidx, w_gidx_nxt;
    logic             r_last, w_last_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_clear_pend, w_clear_pend_nxt;
    logic [2:0]       r_gnt, w_gnt_nxt;
    logic             r_byte_ack, w_byte_ack_nxt;
    logic [2:0]       r_msg_done, w_msg_done_nxt;
    logic             r_write_start, w_write_start_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_clear_all, w_clear_all_nxt;
    logic             r_busy, w_busy_nxt;

    logic [1:0]       w_pick_idx;
    logic             w_req_g;
    logic             w_last_g;
    logic [7:0]       w_data_g;
    logic             w_msg_end;

    function automatic logic [1:0] f_next_idx(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Round-robin search starting at the pointer and wrapping 2 -> 0
    always_comb begin
        w_pick_idx = 2'd0;
        case (r_ptr)
            2'd1:    w_pick_idx = I_REQ[1] ? 2'd1 : (I_REQ[2] ? 2'd2 : 2'd0);
            2'd2:    w_pick_idx = I_REQ[2] ? 2'd2 : (I_REQ[0] ? 2'd0 : 2'd1);
            default: w_pick_idx = I_REQ[0] ? 2'd0 : (I_REQ[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        w_req_g  = 1'b0;
        w_last_g = 1'b0;
        w_data_g = 8'h00;
        case (r_gidx)
            2'd0: begin w_req_g = I_REQ[0]; w_last_g = I_LAST[0]; w_data_g = I_DATA0; end
            2'd1: begin w_req_g = I_REQ[1]; w_last_g = I_LAST[1]; w_data_g = I_DATA1; end
            2'd2: begin w_req_g = I_REQ[2]; w_last_g = I_LAST[2]; w_data_g = I_DATA2; end
            default: ;
        endcase
    end

    // The count already includes the byte being acknowledged while in ACK
    assign w_msg_end = r_last || (r_count == c_MAX_CNT);

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_state       <= c_WAIT_INIT;
            r_ptr         <= 2'd0;
            r_gidx        <= 2'd0;
            r_last        <= 1'b0;
            r_count       <= '0;
            r_clear_pend  <= 1'b0;
            r_gnt         <= 3'b000;
            r_byte_ack    <= 1'b0;
            r_msg_done    <= 3'b000;
            r_write_start <= 1'b0;
            r_data        <= 8'h00;
            r_clear_all   <= 1'b0;
            r_busy        <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_gidx        <= w_gidx_nxt;
            r_last        <= w_last_nxt;
            r_count       <= w_count_nxt;
            r_clear_pend  <= w_clear_pend_nxt;
            r_gnt         <= w_gnt_nxt;
            r_byte_ack    <= w_byte_ack_nxt;
            r_msg_done    <= w_msg_done_nxt;
            r_write_start <= w_write_start_nxt;
            r_data        <= w_data_nxt;
            r_clear_all   <= w_clear_all_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_WAIT_INIT:  if (I_INIT_DONE) w_state_nxt = c_IDLE;
            c_IDLE: begin
                if (r_clear_pend)  w_state_nxt = c_CLEAR;
                else if (|I_REQ)   w_state_nxt = c_ISSUE;
            end
            c_ISSUE:      w_state_nxt = w_req_g ? c_WAIT_DONE : c_IDLE;
            c_WAIT_DONE:  if (I_WRITE_DONE) w_state_nxt = c_ACK;
            c_ACK:        w_state_nxt = w_msg_end ? c_IDLE : c_ISSUE;
            c_CLEAR:      w_state_nxt = c_CLEAR_WAIT;
            c_CLEAR_WAIT: if (I_WRITE_DONE) w_state_nxt = c_IDLE;
            default:      w_state_nxt = c_WAIT_INIT;
        endcase
    end

    always_comb begin
        w_ptr_nxt         = r_ptr;
        w_gidx_nxt        = r_gidx;
        w_last_nxt        = r_last;
        w_count_nxt       = r_count;
        w_gnt_nxt         = r_gnt;
        w_data_nxt        = r_data;
        w_byte_ack_nxt    = 1'b0;
        w_msg_done_nxt    = 3'b000;
        w_write_start_nxt = 1'b0;
        w_clear_all_nxt   = 1'b0;
        w_clear_pend_nxt  = r_clear_pend | I_CLEAR;
        w_busy_nxt        = (w_state_nxt != c_IDLE);
        case (r_state)
            c_IDLE: begin
                if (r_clear_pend) begin
                    // A clear arriving on this very edge stays pending
                    w_clear_all_nxt  = 1'b1;
                    w_clear_pend_nxt = I_CLEAR;
                end else if (|I_REQ) begin
                    w_gidx_nxt  = w_pick_idx;
                    w_gnt_nxt   = 3'b001 << w_pick_idx;
                    w_count_nxt = '0;
                end
            end
            c_ISSUE: begin
                if (w_req_g) begin
                    w_data_nxt        = w_data_g;
                    w_last_nxt        = w_last_g;
                    w_write_start_nxt = 1'b1;
                end else begin
                    w_gnt_nxt = 3'b000;
                    w_ptr_nxt = f_next_idx(r_gidx);
                end
            end
            c_WAIT_DONE: begin
                if (I_WRITE_DONE) begin
                    w_byte_ack_nxt = 1'b1;
                    if (r_count != c_MAX_CNT) w_count_nxt = r_count + c_CNT_ONE;
                end
            end
            c_ACK: begin
                if (w_msg_end) begin
                    w_msg_done_nxt = r_gnt;
                    w_gnt_nxt      = 3'b000;
                    w_ptr_nxt      = f_next_idx(r_gidx);
                end
            end
            default: ;
        endcase
    end

    assign O_GNT         = r_gnt;
    assign O_BYTE_ACK    = r_byte_ack;
    assign O_MSG_DONE    = r_msg_done;
    assign O_WRITE_START = r_write_start;
    assign O_DATA        = r_data;
    assign O_CLEAR_ALL   = r_clear_all;
    assign O_BUSY        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_write_arbiter
// Function : self-checking bench with requester models, write-done responder
//            and per-requester byte scoreboards
// Revision : 1.0
// ============================================================================
module tb_lcd_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [7:0] data0, data1, data2;
    logic [2:0] last;
    logic       clr;
    logic       init_done;
    logic       write_done;
    logic [2:0] gnt;
    logic       byte_ack;
    logic [2:0] msg_done;
    logic       write_start;
    logic [7:0] dout;
    logic       clear_all;
    logic       busy;

    logic [2:0] b_req;
    logic [7:0] b_data;
    logic       b_write_done;
    logic [2:0] b_gnt;
    logic       b_byte_ack;
    logic [2:0] b_msg_done;
    logic       b_write_start;
    logic [7:0] b_dout;
    logic       b_clear_all;
    logic       b_busy;

    always #5 clk = ~clk;

    lcd_write_arbiter dut (
        .I_CLK(clk), .I_RST(rst), .I_REQ(req),
        .I_DATA0(data0), .I_DATA1(data1), .I_DATA2(data2),
        .I_LAST(last), .I_CLEAR(clr), .I_INIT_DONE(init_done),
        .I_WRITE_DONE(write_done), .O_GNT(gnt), .O_BYTE_ACK(byte_ack),
        .O_MSG_DONE(msg_done), .O_WRITE_START(write_start), .O_DATA(dout),
        .O_CLEAR_ALL(clear_all), .O_BUSY(busy)
    );

    lcd_write_arbiter #(.MAX_BYTES(4)) dut4 (
        .I_CLK(clk), .I_RST(rst), .I_REQ(b_req),
        .I_DATA0(b_data), .I_DATA1(8'h00), .I_DATA2(8'h00),
        .I_LAST(3'b000), .I_CLEAR(1'b0), .I_INIT_DONE(init_done),
        .I_WRITE_DONE(b_write_done), .O_GNT(b_gnt), .O_BYTE_ACK(b_byte_ack),
        .O_MSG_DONE(b_msg_done), .O_WRITE_START(b_write_start), .O_DATA(b_dout),
        .O_CLEAR_ALL(b_clear_all), .O_BUSY(b_busy)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] msg [3][64];
    int         len [3];
    int         idx [3];
    int         rep [3];
    logic [7:0] q0[$], q1[$], q2[$], qb[$];
    int         log_q[$];

    bit         wd_auto = 1'b1;
    int         wd_cnt = 0, b_wd_cnt = 0;
    int         n_writes = 0, n_acks = 0, n_clears = 0, b_writes = 0;
    logic [2:0] done_seen = 3'b000, b_done_seen = 3'b000;
    logic [2:0] first_gnt = 3'b000;
    int         mg;
    logic [7:0] exp_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    function automatic void refresh();
        data0 = msg[0][idx[0]];
        data1 = msg[1][idx[1]];
        data2 = msg[2][idx[2]];
        last  = {idx[2] == len[2] - 1, idx[1] == len[1] - 1, idx[0] == len[0] - 1};
    endfunction

    function automatic void push_exp(input int r, input logic [7:0] b);
        case (r)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    task automatic load(input int r, input int n, input logic [7:0] seed, input int reps, input bit push);
        len[r] = n;
        idx[r] = 0;
        rep[r] = reps;
        for (int k = 0; k < n; k++) msg[r][k] = seed + 8'(k);
        if (push)
            for (int p = 0; p <= reps; p++)
                for (int k = 0; k < n; k++) push_exp(r, msg[r][k]);
        refresh();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((req != 3'b000 || busy) && n < budget);
        check({name, "_idle"}, 32'(req == 3'b000 && !busy), 32'd1);
    endtask

    // Write-done responders, requester models and output scoreboards
    initial forever begin
        @(negedge clk);
        if (!wd_auto) begin
            wd_cnt = 0;
            write_done = 1'b0;
        end else begin
            write_done = 1'b0;
            if (wd_cnt != 0) begin
                wd_cnt--;
                if (wd_cnt == 0) write_done = 1'b1;
            end
            if (write_start || clear_all) wd_cnt = 3;
        end
        b_write_done = 1'b0;
        if (b_wd_cnt != 0) begin
            b_wd_cnt--;
            if (b_wd_cnt == 0) b_write_done = 1'b1;
        end
        if (b_write_start) b_wd_cnt = 3;

        if (write_start) begin
            n_writes++;
            mg = oh2idx(gnt);
            log_q.push_back(mg);
            if (mg == 0 && q0.size() != 0)      check("wr_data_r0", 32'(dout), 32'(q0.pop_front()));
            else if (mg == 1 && q1.size() != 0) check("wr_data_r1", 32'(dout), 32'(q1.pop_front()));
            else if (mg == 2 && q2.size() != 0) check("wr_data_r2", 32'(dout), 32'(q2.pop_front()));
            else check("wr_unexpected_gnt", 32'(gnt), 32'd0);
        end
        if (clear_all) begin
            n_clears++;
            log_q.push_back(9);
        end
        if (gnt != 3'b000 && first_gnt == 3'b000) first_gnt = gnt;
        done_seen = done_seen | msg_done;
        if (byte_ack) begin
            n_acks++;
            mg = oh2idx(gnt);
            if (mg < 3) idx[mg] = idx[mg] + 1;
        end
        for (int r = 0; r < 3; r++) begin
            if (msg_done[r]) begin
                if (rep[r] > 0) begin
                    rep[r]--;
                    idx[r] = 0;
                end else begin
                    req[r] = 1'b0;
                end
            end
        end
        refresh();

        if (b_write_start) begin
            b_writes++;
            if (qb.size() != 0) begin
                exp_b = qb.pop_front();
                check("guard_data", 32'(b_dout), 32'(exp_b));
            end else begin
                check("guard_extra_write", 32'(b_writes), 32'd4);
            end
        end
        if (b_byte_ack) b_data = b_data + 8'd1;
        if (b_msg_done != 3'b000) begin
            b_done_seen = b_done_seen | b_msg_done;
            b_req = 3'b000;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    typedef struct {
        logic [2:0] req;
        int         len;
        logic [7:0] seed;
        logic [2:0] exp_gnt;
        logic [2:0] exp_done;
        int         exp_writes;
    } vec_t;

    vec_t vecs [7];
    int   w0, a0, n0;
    int   hello [5];

    initial begin
        vecs[0] = '{3'b001, 1, 8'h10, 3'b001, 3'b001, 1};
        vecs[1] = '{3'b100, 3, 8'h20, 3'b100, 3'b100, 3};
        vecs[2] = '{3'b110, 2, 8'h30, 3'b010, 3'b110, 4};
        vecs[3] = '{3'b101, 2, 8'h40, 3'b001, 3'b101, 4};
        vecs[4] = '{3'b111, 1, 8'h50, 3'b001, 3'b111, 3};
        vecs[5] = '{3'b010, 5, 8'h60, 3'b010, 3'b010, 5};
        vecs[6] = '{3'b011, 1, 8'h70, 3'b001, 3'b011, 2};
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

        rst = 1'b1; init_done = 1'b0; req = 3'b000; clr = 1'b0;
        b_req = 3'b000; b_data = 8'h00; write_done = 1'b0; b_write_done = 1'b0;
        for (int r = 0; r < 3; r++) begin
            len[r] = 0; idx[r] = 0; rep[r] = 0;
            for (int k = 0; k < 64; k++) msg[r][k] = 8'h00;
        end
        refresh();
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_outs", 32'({byte_ack, msg_done, write_start, clear_all}), 32'd0);
        check("rst_data", 32'(dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;

        // Requests and clears are held off until init completes; clear goes first
        load(2, 1, 8'hE2, 0, 1'b1);
        req = 3'b100;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (5) @(negedge clk);
        check("init_no_write", 32'(n_writes + n_clears), 32'd0);
        check("init_busy", 32'({busy, gnt}), 32'h8);
        init_done = 1'b1;
        wait_idle(100, "init");
        check("init_log_len", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            check("init_log0", 32'(log_q[0]), 32'd9);
            check("init_log1", 32'(log_q[1]), 32'd2);
        end

        // Fairness: every requester always requesting, 1-byte messages
        log_q.delete();
        for (int r = 0; r < 3; r++) load(r, 1, 8'hA0 + 8'(r), 1, 1'b1);
        req = 3'b111;
        wait_idle(300, "fair");
        check("fair_len", 32'(log_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) check("fair_order", 32'(log_q[i]), 32'(i % 3));

        // HELLO on requester 0
        w0 = n_writes; a0 = n_acks; done_seen = 3'b000;
        len[0] = 5; idx[0] = 0; rep[0] = 0;
        for (int k = 0; k < 5; k++) begin
            msg[0][k] = 8'(hello[k]);
            push_exp(0, 8'(hello[k]));
        end
        refresh();
        req = 3'b001;
        wait_idle(200, "hello");
        check("hello_writes", 32'(n_writes - w0), 32'd5);
        check("hello_acks", 32'(n_acks - a0), 32'd5);
        check("hello_done", 32'(done_seen), 32'b001);
        check("hello_gnt", 32'(gnt), 32'd0);

        for (int v = 0; v < 7; v++) begin
            w0 = n_writes; done_seen = 3'b000; first_gnt = 3'b000;
            for (int r = 0; r < 3; r++)
                if (vecs[v].req[r]) load(r, vecs[v].len, vecs[v].seed + 8'(r * 8), 0, 1'b1);
            req = vecs[v].req;
            wait_idle(400, "vec");
            check("vec_first_gnt", 32'(first_gnt), 32'(vecs[v].exp_gnt));
            check("vec_done", 32'(done_seen), 32'(vecs[v].exp_done));
            check("vec_writes", 32'(n_writes - w0), 32'(vecs[v].exp_writes));
            check("vec_sb_left", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        end

        // Clear during byte 2 of a 4-byte message, with another request waiting
        log_q.delete(); done_seen = 3'b000; w0 = n_writes;
        load(2, 4, 8'h80, 0, 1'b1);
        load(0, 1, 8'h8F, 0, 1'b1);
        req = 3'b100;
        n0 = 0;
        while (n_writes - w0 < 2 && n0 < 100) begin @(negedge clk); n0++; end
        clr = 1'b1;
        req[0] = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_idle(400, "clr");
        check("clr_log_len", 32'(log_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            check("clr_order", 32'(log_q[i]), (i < 4) ? 32'd2 : ((i == 4) ? 32'd9 : 32'd0));
        check("clr_done", 32'(done_seen), 32'b101);

        // Abort: requester 1 withdraws after its first byte
        done_seen = 3'b000; w0 = n_writes; a0 = n_acks;
        load(1, 3, 8'h90, 0, 1'b0);
        push_exp(1, 8'h90);
        req = 3'b010;
        n0 = 0;
        while (n_acks == a0 && n0 < 100) begin @(negedge clk); n0++; end
        req[1] = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_writes", 32'(n_writes - w0), 32'd1);
        check("abort_done", 32'(done_seen), 32'd0);
        check("abort_idle", 32'({gnt, busy}), 32'd0);

        // Length guard on the MAX_BYTES=4 instance, last never flagged
        for (int k = 0; k < 4; k++) qb.push_back(8'hC0 + 8'(k));
        b_data = 8'hC0;
        b_req = 3'b001;
        n0 = 0;
        while ((b_req != 3'b000 || b_busy) && n0 < 200) begin @(negedge clk); n0++; end
        repeat (10) @(negedge clk);
        check("guard_writes", 32'(b_writes), 32'd4);
        check("guard_done", 32'(b_done_seen), 32'b001);
        check("guard_release", 32'({b_gnt, b_busy}), 32'd0);

        // Asynchronous reset while waiting for write-done
        wd_auto = 1'b0; done_seen = 3'b000; w0 = n_writes;
        load(0, 2, 8'hD0, 0, 1'b1);
        req = 3'b001;
        n0 = 0;
        while (n_writes == w0 && n0 < 50) begin @(negedge clk); n0++; end
        @(negedge clk);
        #2;
        init_done = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_outs", 32'({byte_ack, msg_done, write_start, clear_all}), 32'd0);
        check("arst_data", 32'(dout), 32'd0);
        check("arst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        push_exp(0, 8'hD0);
        push_exp(0, 8'hD1);
        repeat (6) @(negedge clk);
        check("arst_hold", 32'({busy, gnt}), 32'h8);
        check("arst_no_write", 32'(n_writes - w0), 32'd1);
        check("arst_no_done", 32'(done_seen), 32'd0);
        wd_auto = 1'b1;
        init_done = 1'b1;
        wait_idle(200, "arst");
        check("arst_resume_writes", 32'(n_writes - w0), 32'd3);
        check("arst_resume_done", 32'(done_seen), 32'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
